main_fsm: RTL and testbench

//  Multicycle control sequencer for the ARM core. It steps each instruction through

---
 rtl/main_fsm_if.sv | 37 +++
 rtl/main_fsm.sv | 168 ++++++++++++++++
 tb/tb_main_fsm.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/main_fsm_if.sv
// Control bundle between the multicycle sequencer and the datapath/memory side.
// The master is the sequencer. The slave is the datapath, memory and AluDecoder side.
interface main_fsm_if #(
  parameter int CNT_W = 32
);
  logic [1:0]       op;
  logic [5:0]       funct;
  logic             no_write;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_w;
  logic             adr_src;
  logic             ir_write;
  logic             next_pc;
  logic             reg_w;
  logic             branch;
  logic             alu_op;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       result_src;
  logic             illegal;
  logic             bus_err;
  logic             instr_done;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op, funct, no_write, mem_ready,
    output mem_req, mem_w, adr_src, ir_write, next_pc, reg_w, branch, alu_op,
           alu_src_a, alu_src_b, result_src, illegal, bus_err, instr_done, retired
  );

  modport slave (
    output op, funct, no_write, mem_ready,
    input  mem_req, mem_w, adr_src, ir_write, next_pc, reg_w, branch, alu_op,
           alu_src_a, alu_src_b, result_src, illegal, bus_err, instr_done, retired
  );
endinterface

// File: rtl/main_fsm.sv
// Multicycle ARM control sequencer: fetch/decode/execute/memory/writeback with
// a bounded memory-ready wait and a retired-instruction counter.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 -> PC on mem_ready
// DECODE   | read registers, PC+8 presented as R15
// EXECUTER | ALU op on register operand
// EXECUTEI | ALU op on immediate operand
// ALUWB    | write ALU result to register file
// MEMADR   | compute load/store address
// MEMREAD  | load access, wait for mem_ready
// MEMWB    | write loaded data to register file
// MEMWRITE | store access, wait for mem_ready
// BRANCH   | compute branch target
module main_fsm #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  main_fsm_if.master bus
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;

  localparam int              WC_W      = $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

  logic [3:0]       state, state_nxt;
  logic [WC_W-1:0]  wait_cnt;
  logic [CNT_W-1:0] retired;
  logic             mem_state, timeout, done, illegal;

  assign mem_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  // The WAIT_MAX-th consecutive not-ready cycle aborts; ready on that cycle still wins.
  assign timeout   = mem_state && !bus.mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state)
      FETCH:    if (bus.mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (bus.op)
          2'b00:   state_nxt = bus.funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_nxt = MEMADR;
          2'b10:   state_nxt = BRANCH;
          default: begin
            state_nxt = FETCH;
            illegal   = 1'b1;
            done      = 1'b1;
          end
        endcase
      end
      EXECUTER, EXECUTEI: begin
        if (bus.no_write) begin
          state_nxt = FETCH;
          done      = 1'b1;
        end else begin
          state_nxt = ALUWB;
        end
      end
      MEMADR:   state_nxt = bus.funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD: begin
        if (bus.mem_ready)  state_nxt = MEMWB;
        else if (timeout)   state_nxt = FETCH;
      end
      MEMWRITE: begin
        if (bus.mem_ready) begin
          state_nxt = FETCH;
          done      = 1'b1;
        end else if (timeout) begin
          state_nxt = FETCH;
        end
      end
      ALUWB, MEMWB, BRANCH: begin
        state_nxt = FETCH;
        done      = 1'b1;
      end
      default:  state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state <= state_nxt;
      // Any exit from the waiting condition, including a FETCH retry, restarts the count.
      if (mem_state && !bus.mem_ready && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                                         wait_cnt <= '0;
      if (done) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_w      = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.next_pc    = 1'b0;
    bus.reg_w      = 1'b0;
    bus.branch     = 1'b0;
    bus.alu_op     = 1'b0;
    bus.alu_src_a  = 2'd0;
    bus.alu_src_b  = 2'd0;
    bus.result_src = 2'd0;
    case (state)
      FETCH: begin
        bus.mem_req    = 1'b1;
        bus.ir_write   = bus.mem_ready;
        bus.next_pc    = bus.mem_ready;
        bus.alu_src_a  = 2'd1;
        bus.alu_src_b  = 2'd2;
        bus.result_src = 2'd2;
      end
      DECODE: begin
        bus.alu_src_a  = 2'd1;
        bus.alu_src_b  = 2'd2;
        bus.result_src = 2'd2;
      end
      EXECUTER: bus.alu_op = 1'b1;
      EXECUTEI: begin
        bus.alu_op    = 1'b1;
        bus.alu_src_b = 2'd1;
      end
      ALUWB:    bus.reg_w = 1'b1;
      MEMADR:   bus.alu_src_b = 2'd1;
      MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
      end
      MEMWB: begin
        bus.reg_w      = 1'b1;
        bus.result_src = 2'd1;
      end
      MEMWRITE: begin
        bus.mem_req = 1'b1;
        bus.mem_w   = 1'b1;
        bus.adr_src = 1'b1;
      end
      BRANCH: begin
        bus.branch     = 1'b1;
        bus.alu_src_b  = 2'd1;
        bus.result_src = 2'd2;
      end
      default: ;
    endcase
  end

  assign bus.illegal    = illegal;
  assign bus.bus_err    = timeout;
  assign bus.instr_done = done;
  assign bus.retired    = retired;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: walks each instruction class cycle by cycle and
// compares the decoded control word, pulses and retired count against hand values.
module tb_main_fsm;

  localparam int WAIT_MAX = 16;
  localparam int CNT_W    = 32;

  localparam int S_FETCH = 0, S_DECODE = 1, S_EXR = 2, S_EXI = 3, S_ALUWB = 4,
                 S_MEMADR = 5, S_MEMRD = 6, S_MEMWB = 7, S_MEMWR = 8, S_BR = 9;

  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;
  int   exp_ret = 0;

  main_fsm_if #(.CNT_W(CNT_W)) bus ();

  main_fsm #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_w, adr_src, ir_write, next_pc, reg_w, branch, alu_op, a, b, rs}
  function automatic logic [13:0] exp_sig(input int st, input logic r);
    case (st)
      S_FETCH:  return {1'b1, 1'b0, 1'b0, r, r, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd2};
      S_DECODE: return {8'b0000_0000, 2'd1, 2'd2, 2'd2};
      S_EXR:    return {8'b0000_0001, 2'd0, 2'd0, 2'd0};
      S_EXI:    return {8'b0000_0001, 2'd0, 2'd1, 2'd0};
      S_ALUWB:  return {8'b0000_0100, 2'd0, 2'd0, 2'd0};
      S_MEMADR: return {8'b0000_0000, 2'd0, 2'd1, 2'd0};
      S_MEMRD:  return {8'b1010_0000, 2'd0, 2'd0, 2'd0};
      S_MEMWB:  return {8'b0000_0100, 2'd0, 2'd0, 2'd1};
      S_MEMWR:  return {8'b1110_0000, 2'd0, 2'd0, 2'd0};
      S_BR:     return {8'b0000_0010, 2'd0, 2'd1, 2'd2};
      default:  return 14'h3fff;
    endcase
  endfunction

  function automatic logic [13:0] obs_sig();
    return {bus.mem_req, bus.mem_w, bus.adr_src, bus.ir_write, bus.next_pc, bus.reg_w,
            bus.branch, bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.result_src};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: apply mem_ready, check the current state's outputs, take the edge.
  task automatic step(input string tag, input int st, input logic r,
                      input logic ill, input logic be, input logic done);
    bus.mem_ready = r;
    #2;
    chk({tag, ".ctrl"},    32'(obs_sig()),      32'(exp_sig(st, r)));
    chk({tag, ".illegal"}, 32'(bus.illegal),    32'(ill));
    chk({tag, ".bus_err"}, 32'(bus.bus_err),    32'(be));
    chk({tag, ".done"},    32'(bus.instr_done), 32'(done));
    chk({tag, ".retired"}, bus.retired,         32'(exp_ret));
    @(posedge clk);
    #1;
    if (done) exp_ret++;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] funct, input logic nw);
    bus.op       = op;
    bus.funct    = funct;
    bus.no_write = nw;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    set_instr(2'b00, 6'b000100, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ctrl",     32'(obs_sig()),    32'(exp_sig(S_FETCH, 1'b0)));
    chk("reset.ir_write", 32'(bus.ir_write), 32'd0);
    chk("reset.mem_req",  32'(bus.mem_req),  32'd1);
    chk("reset.retired",  bus.retired,       32'd0);
    rst_n = 1'b1;

    // ADD register, ready high every cycle including non-memory states
    step("add.f", S_FETCH, 1, 0, 0, 0);
    step("add.d", S_DECODE, 1, 0, 0, 0);
    step("add.e", S_EXR, 1, 0, 0, 0);
    step("add.w", S_ALUWB, 1, 0, 0, 1);
    chk("add.retired", bus.retired, 32'd1);

    // CMP skips writeback
    set_instr(2'b00, 6'b010101, 1'b1);
    step("cmp.f", S_FETCH, 1, 0, 0, 0);
    step("cmp.d", S_DECODE, 0, 0, 0, 0);
    step("cmp.e", S_EXR, 0, 0, 0, 1);

    // ADD immediate
    set_instr(2'b00, 6'b101000, 1'b0);
    step("addi.f", S_FETCH, 1, 0, 0, 0);
    step("addi.d", S_DECODE, 0, 0, 0, 0);
    step("addi.e", S_EXI, 0, 0, 0, 0);
    step("addi.w", S_ALUWB, 0, 0, 0, 1);

    // LDR with two wait cycles in MEMREAD
    set_instr(2'b01, 6'b011001, 1'b0);
    step("ldr.f", S_FETCH, 1, 0, 0, 0);
    step("ldr.d", S_DECODE, 0, 0, 0, 0);
    step("ldr.a", S_MEMADR, 0, 0, 0, 0);
    step("ldr.r0", S_MEMRD, 0, 0, 0, 0);
    step("ldr.r1", S_MEMRD, 0, 0, 0, 0);
    step("ldr.r2", S_MEMRD, 1, 0, 0, 0);
    step("ldr.wb", S_MEMWB, 0, 0, 0, 1);

    // STR completing immediately
    set_instr(2'b01, 6'b011000, 1'b0);
    step("str.f", S_FETCH, 1, 0, 0, 0);
    step("str.d", S_DECODE, 0, 0, 0, 0);
    step("str.a", S_MEMADR, 0, 0, 0, 0);
    step("str.w", S_MEMWR, 1, 0, 0, 1);

    // STR with mem_ready stuck low: abort on the WAIT_MAX-th wait cycle
    step("strto.f", S_FETCH, 1, 0, 0, 0);
    step("strto.d", S_DECODE, 0, 0, 0, 0);
    step("strto.a", S_MEMADR, 0, 0, 0, 0);
    for (int i = 0; i < WAIT_MAX - 1; i++) step($sformatf("strto.w%0d", i), S_MEMWR, 0, 0, 0, 0);
    step("strto.err", S_MEMWR, 0, 0, 1, 0);
    chk("strto.retired", bus.retired, 32'd5);

    // Ready arriving exactly on the timeout cycle completes normally
    step("strlast.f", S_FETCH, 1, 0, 0, 0);
    step("strlast.d", S_DECODE, 0, 0, 0, 0);
    step("strlast.a", S_MEMADR, 0, 0, 0, 0);
    for (int i = 0; i < WAIT_MAX - 1; i++) step($sformatf("strlast.w%0d", i), S_MEMWR, 0, 0, 0, 0);
    step("strlast.ok", S_MEMWR, 1, 0, 0, 1);

    // Branch
    set_instr(2'b10, 6'b000000, 1'b0);
    step("b.f", S_FETCH, 1, 0, 0, 0);
    step("b.d", S_DECODE, 0, 0, 0, 0);
    step("b.br", S_BR, 0, 0, 0, 1);

    // Illegal opcode
    set_instr(2'b11, 6'b000000, 1'b0);
    step("ill.f", S_FETCH, 1, 0, 0, 0);
    step("ill.d", S_DECODE, 0, 1, 0, 1);

    // FETCH timeout retries in FETCH with a fresh wait count
    for (int i = 0; i < WAIT_MAX - 1; i++) step($sformatf("fto.w%0d", i), S_FETCH, 0, 0, 0, 0);
    step("fto.err", S_FETCH, 0, 0, 1, 0);
    step("fto.retry", S_FETCH, 0, 0, 0, 0);
    step("fto.f", S_FETCH, 1, 0, 0, 0);
    step("fto.d", S_DECODE, 0, 1, 0, 1);
    chk("fto.retired", bus.retired, 32'd9);

    // Asynchronous reset in the middle of an instruction
    set_instr(2'b00, 6'b000100, 1'b0);
    step("ar.f", S_FETCH, 1, 0, 0, 0);
    step("ar.d", S_DECODE, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.ctrl",    32'(obs_sig()), 32'(exp_sig(S_FETCH, 1'b0)));
    chk("arst.retired", bus.retired,    32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
